// File: rtl/ram_resp.sv
`default_nettype none
// ============================================================================
// Module   : ram_resp
// Brief    : Word-organised memory responder for the ram_cs/ram_we/ram_oe
//            strobe interface, with wait states, fault flags and overrun flag.
// Revision : 1.0
// ============================================================================
module ram_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cs,
    input  logic        ram_we,
    input  logic        ram_oe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ram_ready,
    output logic        ram_err,
    output logic        ram_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_wait = 4'(WAIT_CYC);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_req;
    logic        w_accept;
    logic        w_access;
    logic        w_fault;
    logic [ADDR_W-1:0] w_idx;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    assign w_req   = ram_cs & (ram_we | ram_oe);
    // Out-of-range addresses fault instead of aliasing onto low words.
    assign w_fault = (|r_addr[1:0]) | (|r_addr[31:ADDR_W+2]);
    assign w_idx   = r_addr[ADDR_W+1:2];

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next   = BUSY;
                    w_accept = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next   = RESP;
                    w_access = 1'b1;
                end
            end
            RESP: begin
                if (w_req) begin
                    w_next   = BUSY;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            rdata     <= 32'd0;
            ram_ready <= 1'b0;
            ram_err   <= 1'b0;
            ram_ovf   <= 1'b0;
        end else begin
            r_state   <= w_next;
            ram_ready <= w_access;
            ram_err   <= w_access & w_fault;
            if (w_accept) begin
                r_we    <= ram_we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_cnt   <= c_wait;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_we && !w_fault) begin
                rdata <= mem[w_idx];
            end
            if (w_req && r_state == BUSY) begin
                ram_ovf <= 1'b1;
            end
        end
    end

    // Storage has no reset; a reset at the access edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_we && !w_fault) begin
            mem[w_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire
